ov7670_capture: RTL
===================

OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 SHALL have parameter FRAME_W, default 320, meaning pixels per line.
REQ-002 SHALL have parameter FRAME_H, default 240, meaning lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 17, meaning the frame-buffer address width, with 2^ADDR_W >= FRAME_W*FRAME_H.
REQ-004 SHALL have port i_cap_pclk  input  1  camera pixel clock, the only clock; all logic on its rising edge.
REQ-005 SHALL have port i_cap_rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port i_cap_en  input  1  capture enable, sampled only at frame boundaries.
REQ-007 SHALL have port i_cap_vsync  input  1  camera VSYNC, high = vertical blanking.
REQ-008 SHALL have port i_cap_href  input  1  camera HREF, high = valid bytes on data.
REQ-009 SHALL have port i_cap_data  input  8  camera pixel byte bus.
REQ-010 SHALL have port o_cap_wr_en  output  1  frame-buffer write strobe, one cycle per pixel.
REQ-011 SHALL have port o_cap_wr_addr  output  ADDR_W  frame-buffer write address.
REQ-012 SHALL have port o_cap_wr_data  output  16  RGB565 pixel.
REQ-013 SHALL have port o_cap_busy  output  1  high while a frame is being captured.
REQ-014 SHALL have port o_cap_frame_done  output  1  one-cycle pulse at the end of each captured frame.
REQ-015 SHALL have port o_cap_err  output  1  frame-geometry error flag for the last frame.
REQ-016 SHALL have port o_cap_frame_cnt  output  8  count of completed frames, wrapping at 255 to 0.

Function
REQ-017 SHALL register vsync, href and data in one input stage; all decisions use the registered copies.
REQ-018 SHALL implement the states IDLE, WAIT_VS, WAIT_START, CAPTURE and DONE.
REQ-019 SHALL move from IDLE to WAIT_VS when i_cap_en=1.
REQ-020 SHALL move from WAIT_VS to WAIT_START when registered vsync=1.
REQ-021 SHALL move from WAIT_START to CAPTURE on registered vsync=0, clearing the address, the line counter, the byte phase and o_cap_err.
REQ-022 SHALL stay in WAIT_START (no CAPTURE entry) when i_cap_en drops there, and SHALL return to IDLE.
REQ-023 SHALL, in CAPTURE with href=1, store the byte as pixel[15:8] on phase 0, assemble pixel[7:0] on phase 1, and toggle the phase on every href=1 cycle.
REQ-024 SHALL, on phase 1, drive o_cap_wr_en=1 on the next edge with o_cap_wr_data = assembled pixel and o_cap_wr_addr = current address, then increment the address.
REQ-025 SHALL give a latency of 2 rising edges from the edge sampling byte 1 on the pins to o_cap_wr_en high.
REQ-026 SHALL, on each href falling edge (registered), increment the line counter, reset the phase to 0, and set o_cap_err if the line pixel count != FRAME_W or the phase was 1; a partial pixel SHALL be discarded.
REQ-027 SHALL suppress the write and set o_cap_err when the address reaches FRAME_W*FRAME_H; the address SHALL saturate and never wrap within a frame.
REQ-028 SHALL end the frame on registered vsync rising in CAPTURE, go to DONE, and set o_cap_err if the line count != FRAME_H.
REQ-029 SHALL, in DONE (one cycle), pulse o_cap_frame_done, increment o_cap_frame_cnt, then go to WAIT_START if i_cap_en=1, else IDLE.
REQ-030 SHALL, when i_cap_en drops during CAPTURE, finish the current frame normally.
REQ-031 SHALL drive o_cap_busy=1 exactly in CAPTURE.
REQ-032 SHALL hold o_cap_err until the next CAPTURE entry.
REQ-033 SHALL treat href=1 while vsync=1 inside CAPTURE as a frame end (vsync wins).

Reset
REQ-034 SHALL, on i_cap_rst=1, force at once: state IDLE, o_cap_wr_en=0, o_cap_wr_addr=0, o_cap_wr_data=0, o_cap_busy=0, o_cap_frame_done=0, o_cap_err=0, o_cap_frame_cnt=0, and clear phase, counters and input registers.
REQ-035 SHALL, when reset hits mid-frame, discard the partial frame and resume only after a full vsync high->low sequence.

Verification
REQ-036 Nominal frame, FRAME_W=4, FRAME_H=2, byte pairs (0xAB,0xCD)... -> 8 writes to addresses 0..7, first data 0xABCD, frame_done pulse, frame_cnt=1, err=0.
REQ-037 A line with 3 pixels plus an odd byte -> partial pixel not written, err=1 after the frame, frame_done still pulses.
REQ-038 3 lines sent with FRAME_H=2 -> writes stop at address 8, err=1.
REQ-039 i_cap_en raised mid-frame -> no writes until the next vsync high->low, then a full frame is captured from address 0.
REQ-040 Reset asserted in the middle of line 1 -> outputs zero immediately; the next complete frame is captured from address 0 with frame_cnt=1.
REQ-041 256 consecutive frames -> frame_cnt wraps to 0, and the write latency is 2 edges on every pixel.

Source files
------------

// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 RGB565 frame capture into a frame buffer write port
module ov7670_capture #(
    parameter int FRAME_W = 320,
    parameter int FRAME_H = 240,
    parameter int ADDR_W  = 17
) (
    input  logic              i_cap_pclk,
    input  logic              i_cap_rst,
    input  logic              i_cap_en,
    input  logic              i_cap_vsync,
    input  logic              i_cap_href,
    input  logic [7:0]        i_cap_data,
    output logic              o_cap_wr_en,
    output logic [ADDR_W-1:0] o_cap_wr_addr,
    output logic [15:0]       o_cap_wr_data,
    output logic              o_cap_busy,
    output logic              o_cap_frame_done,
    output logic              o_cap_err,
    output logic [7:0]        o_cap_frame_cnt
);

    // One spare address bit so the end-of-frame address is representable even
    // when the buffer exactly fills the address space.
    localparam logic [ADDR_W:0] PIX_END = (ADDR_W + 1)'(FRAME_W * FRAME_H);
    localparam logic [ADDR_W:0] ADDR_ONE = (ADDR_W + 1)'(1);
    localparam logic [15:0]     LINE_PIX = 16'(FRAME_W);
    localparam logic [15:0]     FRAME_LINES = 16'(FRAME_H);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        WAIT_START,
        CAPTURE,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic            vs_r;
    logic            hr_r;
    logic            hr_prev;
    logic [7:0]      d_r;
    logic            phase;
    logic [7:0]      pix_hi;
    logic [15:0]     pix;
    logic            pend;
    logic [ADDR_W:0] addr;
    logic [15:0]     line_pix;
    logic [15:0]     line_cnt;

    logic in_cap;
    logic enter_cap;
    logic frame_end;
    logic take;
    logic href_fall;

    assign in_cap    = (state == CAPTURE);
    assign enter_cap = (state == WAIT_START) && i_cap_en && !vs_r;
    // vsync has priority over href: a high vsync always ends the frame
    assign frame_end = in_cap && vs_r;
    assign take      = in_cap && !vs_r && hr_r;
    assign href_fall = in_cap && !vs_r && hr_prev && !hr_r;

    // Input stage: every decision below uses these registered copies
    always_ff @(posedge i_cap_pclk or posedge i_cap_rst) begin
        if (i_cap_rst) begin
            vs_r    <= 1'b0;
            hr_r    <= 1'b0;
            hr_prev <= 1'b0;
            d_r     <= 8'h00;
        end else begin
            vs_r    <= i_cap_vsync;
            hr_r    <= i_cap_href;
            hr_prev <= hr_r;
            d_r     <= i_cap_data;
        end
    end

    // State register
    always_ff @(posedge i_cap_pclk or posedge i_cap_rst) begin
        if (i_cap_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; enable only matters outside an active frame
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (i_cap_en) state_nxt = WAIT_VS;
            WAIT_VS:    if (vs_r) state_nxt = WAIT_START;
            WAIT_START: begin
                if (!i_cap_en) state_nxt = IDLE;
                else if (!vs_r) state_nxt = CAPTURE;
            end
            CAPTURE:    if (vs_r) state_nxt = DONE;
            DONE:       state_nxt = i_cap_en ? WAIT_START : IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        o_cap_busy       = (state == CAPTURE);
        o_cap_frame_done = (state == DONE);
    end

    // Pixel assembly, address generation, geometry checks and frame counter
    always_ff @(posedge i_cap_pclk or posedge i_cap_rst) begin
        if (i_cap_rst) begin
            phase           <= 1'b0;
            pix_hi          <= 8'h00;
            pix             <= 16'h0000;
            pend            <= 1'b0;
            addr            <= '0;
            line_pix        <= 16'h0000;
            line_cnt        <= 16'h0000;
            o_cap_wr_en     <= 1'b0;
            o_cap_wr_addr   <= '0;
            o_cap_wr_data   <= 16'h0000;
            o_cap_err       <= 1'b0;
            o_cap_frame_cnt <= 8'h00;
        end else begin
            o_cap_wr_en <= 1'b0;
            pend        <= 1'b0;
            if (enter_cap) begin
                addr     <= '0;
                line_pix <= 16'h0000;
                line_cnt <= 16'h0000;
                phase    <= 1'b0;
                o_cap_err <= 1'b0;
            end else begin
                if (take) begin
                    if (!phase) begin
                        pix_hi <= d_r;
                        phase  <= 1'b1;
                    end else begin
                        pix      <= {pix_hi, d_r};
                        pend     <= 1'b1;
                        phase    <= 1'b0;
                        line_pix <= line_pix + 16'd1;
                    end
                end
                // A dangling high byte at line end is simply dropped
                if (href_fall) begin
                    line_cnt <= line_cnt + 16'd1;
                    line_pix <= 16'h0000;
                    phase    <= 1'b0;
                    if ((line_pix != LINE_PIX) || phase) o_cap_err <= 1'b1;
                end
                // Address saturates at the frame size; excess pixels flag an error
                if (pend) begin
                    if (addr < PIX_END) begin
                        o_cap_wr_en   <= 1'b1;
                        o_cap_wr_addr <= addr[ADDR_W-1:0];
                        o_cap_wr_data <= pix;
                        addr          <= addr + ADDR_ONE;
                    end else begin
                        o_cap_err <= 1'b1;
                    end
                end
                if (frame_end && (line_cnt != FRAME_LINES)) o_cap_err <= 1'b1;
            end
            if (state == DONE) o_cap_frame_cnt <= o_cap_frame_cnt + 8'd1;
        end
    end

endmodule
